// File: rtl/store_retire_buffer_pkg.sv
// Bus tag fields and drain-state encoding shared by the store retire buffer.
package store_retire_buffer_pkg;

    localparam logic [1:0] WRITE  = 2'b01;
    localparam logic [1:0] MEMORY = 2'b10;
    localparam logic [1:0] DATA   = 2'b11;
    localparam int         TAG_W  = 13;

    typedef enum logic [1:0] {
        SRB_IDLE,
        SRB_REQ,
        SRB_WAIT
    } srbState_t;

    function automatic logic [TAG_W-1:0] writeTag();
        return {WRITE, MEMORY, DATA, 7'b0};
    endfunction

endpackage

// File: rtl/srb_forward_match.sv
// Youngest-match selector: finds the valid entry closest to tail whose address equals lookupAddr.
module srb_forward_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]  entryValid,
    input  logic [ADDR_W-1:0] entryAddr [DEPTH],
    input  logic [DATA_W-1:0] entryData [DEPTH],
    input  logic [PTR_W-1:0]  tailPtr,
    input  logic [ADDR_W-1:0] lookupAddr,
    output logic              lookupHit,
    output logic [DATA_W-1:0] lookupData
);

    logic [DEPTH-1:0] matchVec;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gMatch
        assign matchVec[gi] = entryValid[gi] && (entryAddr[gi] == lookupAddr);
    end

    // Walk from the slot at tail (oldest when full) towards tail-1 so the last hit is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        lookupHit  = 1'b0;
        lookupData = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tailPtr - PTR_W'(k);
            if (matchVec[idx]) begin
                lookupHit  = 1'b1;
                lookupData = entryData[idx];
            end
        end
    end

endmodule

// File: rtl/store_retire_buffer.sv
// In-order store buffer draining to the core bus one write at a time, with store-to-load forwarding.
module store_retire_buffer
    import store_retire_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enqValid,
    output logic                       enqReady,
    input  logic [ADDR_W-1:0]          enqAddr,
    input  logic [DATA_W-1:0]          enqData,
    input  logic                       enqIsCall,
    output logic                       reqcyc,
    output logic [ADDR_W-1:0]          req,
    output logic [DATA_W-1:0]          reqdata,
    output logic [TAG_W-1:0]           reqtag,
    input  logic                       reqack,
    input  logic                       writeack,
    input  logic [ADDR_W-1:0]          lookupAddr,
    output logic                       lookupHit,
    output logic [DATA_W-1:0]          lookupData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       didMemoryWrite,
    output logic                       didCallWriteback
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [DEPTH-1:0]  entryCall;
    logic [DEPTH-1:0]  entryValidReg;
    logic [PTR_W-1:0]  headReg;
    logic [PTR_W-1:0]  tailReg;
    logic [CNT_W-1:0]  countReg;
    srbState_t         stateReg;
    srbState_t         stateNext;
    logic              enqFire;
    logic              retire;

    assign enqReady = (countReg != CNT_W'(DEPTH));
    assign enqFire  = enqValid && enqReady;

    always_comb begin
        stateNext = stateReg;
        retire    = 1'b0;
        case (stateReg)
            SRB_IDLE: if (countReg != '0) stateNext = SRB_REQ;
            SRB_REQ: begin
                if (reqack) begin
                    if (writeack) begin
                        retire    = 1'b1;
                        stateNext = SRB_IDLE;
                    end else begin
                        stateNext = SRB_WAIT;
                    end
                end
            end
            SRB_WAIT: begin
                if (writeack) begin
                    retire    = 1'b1;
                    stateNext = SRB_IDLE;
                end
            end
            default: stateNext = SRB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg         <= SRB_IDLE;
            headReg          <= '0;
            tailReg          <= '0;
            countReg         <= '0;
            entryValidReg    <= '0;
            didMemoryWrite   <= 1'b0;
            didCallWriteback <= 1'b0;
        end else begin
            stateReg         <= stateNext;
            didMemoryWrite   <= retire;
            didCallWriteback <= retire && entryCall[headReg];
            if (enqFire) tailReg <= tailReg + PTR_W'(1);
            if (retire)  headReg <= headReg + PTR_W'(1);
            case ({enqFire, retire})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
            // Enqueue and retire never target the same slot: that needs head==tail, i.e. full or empty.
            for (int i = 0; i < DEPTH; i++) begin
                if (enqFire && tailReg == PTR_W'(i))
                    entryValidReg[i] <= 1'b1;
                else if (retire && headReg == PTR_W'(i))
                    entryValidReg[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enqFire) begin
            entryAddr[tailReg] <= enqAddr;
            entryData[tailReg] <= enqData;
            entryCall[tailReg] <= enqIsCall;
        end
    end

    // Payload is taken straight from head, which only moves on retire, so it is stable throughout REQ.
    assign reqcyc  = (stateReg == SRB_REQ);
    assign req     = reqcyc ? entryAddr[headReg] : '0;
    assign reqdata = reqcyc ? entryData[headReg] : '0;
    assign reqtag  = reqcyc ? writeTag() : '0;
    assign count   = countReg;
    assign empty   = (countReg == '0) && (stateReg == SRB_IDLE);

    srb_forward_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) uForwardMatch (
        .entryValid (entryValidReg),
        .entryAddr  (entryAddr),
        .entryData  (entryData),
        .tailPtr    (tailReg),
        .lookupAddr (lookupAddr),
        .lookupHit  (lookupHit),
        .lookupData (lookupData)
    );

endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed bench for store_retire_buffer (DEPTH=4, 64-bit address/data).
module tb_store_retire_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enqValid;
    logic        enqReady;
    logic [63:0] enqAddr;
    logic [63:0] enqData;
    logic        enqIsCall;
    logic        reqcyc;
    logic [63:0] req;
    logic [63:0] reqdata;
    logic [12:0] reqtag;
    logic        reqack;
    logic        writeack;
    logic [63:0] lookupAddr;
    logic        lookupHit;
    logic [63:0] lookupData;
    logic [2:0]  count;
    logic        empty;
    logic        didMemoryWrite;
    logic        didCallWriteback;

    int passCount   = 0;
    int checkCount  = 0;
    int failCount   = 0;
    int memWrPulses = 0;
    int callPulses  = 0;
    int callOrphans = 0;
    int cycleCnt    = 0;

    always #5 clk = ~clk;

    store_retire_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .enqValid         (enqValid),
        .enqReady         (enqReady),
        .enqAddr          (enqAddr),
        .enqData          (enqData),
        .enqIsCall        (enqIsCall),
        .reqcyc           (reqcyc),
        .req              (req),
        .reqdata          (reqdata),
        .reqtag           (reqtag),
        .reqack           (reqack),
        .writeack         (writeack),
        .lookupAddr       (lookupAddr),
        .lookupHit        (lookupHit),
        .lookupData       (lookupData),
        .count            (count),
        .empty            (empty),
        .didMemoryWrite   (didMemoryWrite),
        .didCallWriteback (didCallWriteback)
    );

    always @(posedge clk) cycleCnt++;

    always @(negedge clk) begin
        if (didMemoryWrite) memWrPulses++;
        if (didCallWriteback) begin
            callPulses++;
            if (!didMemoryWrite) callOrphans++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [63:0] a, input logic [63:0] d, input logic isCall);
        enqValid  = 1'b1;
        enqAddr   = a;
        enqData   = d;
        enqIsCall = isCall;
        step();
        enqValid  = 1'b0;
        enqIsCall = 1'b0;
    endtask

    // Waits (bounded) for a request, captures its payload, then acks after the given delays.
    task automatic busWrite(input int reqDelay, input int wDelay,
                            output logic [63:0] a, output logic [63:0] d);
        int n;
        n = 0;
        while (!reqcyc && n < 20) begin
            step();
            n++;
        end
        check("reqWait", {63'b0, reqcyc}, 64'd1);
        a = req;
        d = reqdata;
        repeat (reqDelay) step();
        if (wDelay == 0) begin
            reqack   = 1'b1;
            writeack = 1'b1;
            step();
            reqack   = 1'b0;
            writeack = 1'b0;
        end else begin
            reqack = 1'b1;
            step();
            reqack = 1'b0;
            repeat (wDelay - 1) step();
            writeack = 1'b1;
            step();
            writeack = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        int base;
        int t0;

        reset      = 1'b0;
        enqValid   = 1'b0;
        enqAddr    = '0;
        enqData    = '0;
        enqIsCall  = 1'b0;
        reqack     = 1'b0;
        writeack   = 1'b0;
        lookupAddr = '0;

        // Reset values
        #2;
        check("rstReqcyc", {63'b0, reqcyc}, 64'd0);
        check("rstReq", req, 64'd0);
        check("rstReqdata", reqdata, 64'd0);
        check("rstReqtag", {51'b0, reqtag}, 64'd0);
        check("rstCount", {61'b0, count}, 64'd0);
        check("rstEmpty", {63'b0, empty}, 64'd1);
        check("rstEnqReady", {63'b0, enqReady}, 64'd1);
        check("rstLookupHit", {63'b0, lookupHit}, 64'd0);
        check("rstLookupData", lookupData, 64'd0);
        check("rstDidMemWr", {63'b0, didMemoryWrite}, 64'd0);
        check("rstDidCall", {63'b0, didCallWriteback}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Reset asserted while a request is outstanding
        enq(64'h5000, 64'h55, 1'b0);
        step();
        check("midReqcyc", {63'b0, reqcyc}, 64'd1);
        lookupAddr = 64'h5000;
        #1;
        check("midLookupHit", {63'b0, lookupHit}, 64'd1);
        #1 reset = 1'b0;
        #1;
        check("asyncRstReqcyc", {63'b0, reqcyc}, 64'd0);
        check("asyncRstReq", req, 64'd0);
        check("asyncRstCount", {61'b0, count}, 64'd0);
        check("asyncRstEmpty", {63'b0, empty}, 64'd1);
        check("asyncRstLookup", {63'b0, lookupHit}, 64'd0);
        reset = 1'b1;
        step();
        check("postRstCount", {61'b0, count}, 64'd0);
        check("postRstEmpty", {63'b0, empty}, 64'd1);
        check("postRstReqcyc", {63'b0, reqcyc}, 64'd0);
        lookupAddr = '0;

        // writeack while idle is ignored
        writeack = 1'b1;
        step();
        writeack = 1'b0;
        step();
        check("idleWackCount", {61'b0, count}, 64'd0);
        check("idleWackPulses", 64'(memWrPulses), 64'd0);

        // Two stores, reqack then writeack two cycles later
        base = memWrPulses;
        enq(64'h1000, 64'hAA, 1'b0);
        check("latencyN", {63'b0, reqcyc}, 64'd0);
        check("oneCount", {61'b0, count}, 64'd1);
        enq(64'h1008, 64'hBB, 1'b0);
        check("latencyN1", {63'b0, reqcyc}, 64'd1);
        check("firstReq", req, 64'h1000);
        check("firstReqdata", reqdata, 64'hAA);
        check("reqtag", {51'b0, reqtag}, 64'h0D80);
        check("twoCount", {61'b0, count}, 64'd2);
        busWrite(0, 2, a, d);
        check("orderAddr0", a, 64'h1000);
        check("orderData0", d, 64'hAA);
        check("retirePulse", {63'b0, didMemoryWrite}, 64'd1);
        check("afterRetireCount", {61'b0, count}, 64'd1);
        busWrite(0, 2, a, d);
        check("orderAddr1", a, 64'h1008);
        check("orderData1", d, 64'hBB);
        step();
        check("twoPulses", 64'(memWrPulses - base), 64'd2);
        check("drainedCount", {61'b0, count}, 64'd0);
        check("drainedEmpty", {63'b0, empty}, 64'd1);

        // Full buffer with bus stalled, then retire while enqueue is offered
        for (int i = 0; i < 4; i++) enq(64'h4000 + 64'(8 * i), 64'h40 + 64'(i), 1'b0);
        check("fullCount", {61'b0, count}, 64'd4);
        check("fullEnqReady", {63'b0, enqReady}, 64'd0);
        check("fullReqcyc", {63'b0, reqcyc}, 64'd1);
        check("fullReq", req, 64'h4000);
        enqValid = 1'b1;
        enqAddr  = 64'h4020;
        enqData  = 64'h44;
        reqack   = 1'b1;
        writeack = 1'b1;
        step();
        reqack   = 1'b0;
        writeack = 1'b0;
        check("fullNoAccept", {61'b0, count}, 64'd3);
        check("fullRetirePulse", {63'b0, didMemoryWrite}, 64'd1);
        step();
        enqValid = 1'b0;
        check("nextAccept", {61'b0, count}, 64'd4);
        check("refullEnqReady", {63'b0, enqReady}, 64'd0);
        t0 = cycleCnt;
        for (int i = 1; i <= 4; i++) begin
            busWrite(0, 0, a, d);
            check("fullDrainAddr", a, 64'h4000 + 64'(8 * i));
            check("fullDrainData", d, 64'h40 + 64'(i));
        end
        check("throughput", 64'(cycleCnt - t0), 64'd7);
        step();
        check("fullDrainEmpty", {63'b0, empty}, 64'd1);

        // Youngest-match forwarding
        lookupAddr = 64'h2000;
        enq(64'h2000, 64'h11, 1'b0);
        check("fwdHit1", {63'b0, lookupHit}, 64'd1);
        check("fwdData1", lookupData, 64'h11);
        enq(64'h2000, 64'h22, 1'b0);
        check("fwdHit2", {63'b0, lookupHit}, 64'd1);
        check("fwdYoungest", lookupData, 64'h22);
        lookupAddr = 64'h2008;
        #1;
        check("fwdMissHit", {63'b0, lookupHit}, 64'd0);
        check("fwdMissData", lookupData, 64'd0);
        lookupAddr = 64'h2000;
        #1;
        busWrite(1, 1, a, d);
        check("fwdDrainAddr", a, 64'h2000);
        check("fwdDrainData", d, 64'h11);
        check("fwdAfterOne", lookupData, 64'h22);
        busWrite(2, 0, a, d);
        check("fwdAfterAllHit", {63'b0, lookupHit}, 64'd0);
        check("fwdAfterAllData", lookupData, 64'd0);
        lookupAddr = '0;

        // Call-flagged write
        base = callPulses;
        enq(64'h6000, 64'h66, 1'b1);
        enq(64'h6008, 64'h67, 1'b0);
        busWrite(0, 1, a, d);
        check("callPulse", {63'b0, didCallWriteback}, 64'd1);
        check("callMemPulse", {63'b0, didMemoryWrite}, 64'd1);
        busWrite(0, 0, a, d);
        check("noCallPulse", {63'b0, didCallWriteback}, 64'd0);
        check("plainMemPulse", {63'b0, didMemoryWrite}, 64'd1);
        step();
        check("callPulseCount", 64'(callPulses - base), 64'd1);
        check("callOrphans", 64'(callOrphans), 64'd0);

        // Pointer wrap with random bus delays
        for (int r = 0; r < 5; r++) begin
            enq(64'h3000 + 64'(16 * r), 64'hC0DE_0000 + 64'(2 * r), 1'b0);
            enq(64'h3008 + 64'(16 * r), 64'hC0DE_0001 + 64'(2 * r), 1'b0);
            for (int j = 0; j < 2; j++) begin
                busWrite(int'($urandom_range(3)), int'($urandom_range(3)), a, d);
                check("wrapAddr", a, 64'h3000 + 64'(16 * r + 8 * j));
                check("wrapData", d, 64'hC0DE_0000 + 64'(2 * r + j));
            end
        end
        step();
        check("wrapCount", {61'b0, count}, 64'd0);
        check("wrapEmpty", {63'b0, empty}, 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
